// File: rtl/brisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : brisc_pkg
// Description : Shared types for the brisc memory subsystem.
// Revision    : 1.0 - initial release
// ============================================================================
package brisc_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } data_size_e;

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Request/response bundle between the cache arbiter and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);

    logic                     mem_req;
    logic                     mem_write;
    brisc_pkg::data_size_e    data_size;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_data;
    logic                     mem_ready;
    logic                     mem_resp_valid;
    logic [DATA_WIDTH-1:0]    mem_resp_data;

    modport master (
        output mem_req, mem_write, data_size, mem_addr, mem_data,
        input  mem_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req, mem_write, data_size, mem_addr, mem_data,
        output mem_ready, mem_resp_valid, mem_resp_data
    );

endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Fixed-latency, single-outstanding sized load/store responder.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import brisc_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_WORDS     = 4096,
    parameter int LATENCY       = 5
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    mem_responder_if.slave  bus
);

    localparam int         c_INDEX_WIDTH = $clog2(MEM_WORDS);
    localparam logic [7:0] c_LAT_M1      = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                   r_state;
    logic [7:0]               r_count;
    logic                     r_ready;
    logic                     r_resp_valid;
    logic                     r_write;
    data_size_e               r_size;
    logic [c_INDEX_WIDTH-1:0] r_index;
    logic [1:0]               r_offset;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_hold_data;
    logic [DATA_WIDTH-1:0]    r_mem [MEM_WORDS];

    logic [1:0]               w_offset;
    logic [3:0]               w_size_mask;
    logic [3:0]               w_be;
    logic [DATA_WIDTH-1:0]    w_lane_mask;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic [DATA_WIDTH-1:0]    w_load_data;
    logic [DATA_WIDTH-1:0]    w_resp_data;
    logic                     w_unused_addr;

    // Offset is forced to the natural alignment of the access size.
    always_comb begin
        w_offset = bus.mem_addr[1:0];
        case (bus.data_size)
            WORD:    w_offset = 2'b00;
            HALF:    w_offset = {bus.mem_addr[1], 1'b0};
            default: w_offset = bus.mem_addr[1:0];
        endcase
    end

    always_comb begin
        w_size_mask = 4'b1111;
        case (r_size)
            BYTE:    w_size_mask = 4'b0001;
            HALF:    w_size_mask = 4'b0011;
            default: w_size_mask = 4'b1111;
        endcase
    end

    assign w_be          = w_size_mask << r_offset;
    assign w_lane_mask   = {{8{w_size_mask[3]}}, {8{w_size_mask[2]}},
                            {8{w_size_mask[1]}}, {8{w_size_mask[0]}}};
    assign w_wdata       = r_wdata << {r_offset, 3'b000};
    assign w_load_data   = (r_mem[r_index] >> {r_offset, 3'b000}) & w_lane_mask;
    assign w_resp_data   = r_write ? '0 : w_load_data;
    assign w_unused_addr = ^bus.mem_addr[ADDRESS_WIDTH-1:c_INDEX_WIDTH+2];

    assign bus.mem_ready      = r_ready;
    assign bus.mem_resp_valid = r_resp_valid;
    assign bus.mem_resp_data  = (r_state == ST_RESP) ? w_resp_data : r_hold_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_write      <= 1'b0;
            r_size       <= BYTE;
            r_index      <= '0;
            r_offset     <= '0;
            r_wdata      <= '0;
            r_hold_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_req) begin
                        r_write  <= bus.mem_write;
                        r_size   <= bus.data_size;
                        r_index  <= bus.mem_addr[2 +: c_INDEX_WIDTH];
                        r_offset <= w_offset;
                        r_wdata  <= bus.mem_data;
                        r_count  <= c_LAT_M1;
                        r_ready  <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state      <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    // The last BUSY cycle is the one where the count expires.
                    if (r_count <= 8'd1) begin
                        r_count      <= '0;
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                    r_hold_data  <= w_resp_data;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                end
            endcase
        end
    end

    // A reset during RESP forces IDLE asynchronously, which suppresses this write.
    always_ff @(posedge clk) begin
        if (r_state == ST_RESP && r_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[r_index][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
